overture_io_host: RTL
=====================

# overture_io_host

Host-side I/O endpoint for the OVERTURE 8-bit CPU, attached to its `arch_input_*` and `arch_output_*` ports. An input FIFO is filled by a host over a valid/ready stream and drained by CPU input reads. An output FIFO captures CPU output writes and is drained by the host over a second valid/ready stream. Sticky error flags report CPU reads from an empty FIFO and CPU writes into a full one, because the CPU cannot stall.

## Interface
- `DEPTH`, 16, entries per FIFO; power of two, ≥2.
- `BIT_WIDTH`, 8, data width; must match CPU datapath.
- `clk` in 1: single clock, shared with CPU.
- `rst` in 1: asynchronous, active-high reset.
- `arch_input_enable` in 1: CPU input read strobe, sampled at `clk` rising edge.
- `arch_input_value` out BIT_WIDTH: head of input FIFO, combinational.
- `arch_output_enable` in 1: CPU output write strobe.
- `arch_output_value` in BIT_WIDTH: CPU output byte.
- `in_valid` in 1: host byte available.
- `in_data` in BIT_WIDTH: host byte.
- `in_ready` out 1: input FIFO can accept a byte.
- `out_valid` out 1: output FIFO non-empty.
- `out_data` out BIT_WIDTH: head of output FIFO.
- `out_ready` in 1: host accepts `out_data`.
- `clr_flags` in 1: one-cycle pulse that clears the sticky flags.
- `in_underflow` out 1: sticky; CPU read an empty input FIFO.
- `out_overflow` out 1: sticky; CPU wrote a full output FIFO.
- `in_level`, `out_level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Input FIFO**
  - Host push when `in_valid && in_ready`; `in_ready = !in_full`.
  - A pop that happens in the same cycle as a push does not free a slot for that push.
  - `arch_input_value` = head entry when non-empty, else 0. There is no bypass from `in_data`.
  - CPU pop on a cycle with `arch_input_enable` and not empty.
  - `arch_input_enable` while empty: no pop, `in_underflow` set.
- **Output FIFO**
  - CPU push on `arch_output_enable` if `!out_full || (out_valid && out_ready)`.
  - A write that does not meet that condition is dropped and sets `out_overflow`.
  - Host pop when `out_valid && out_ready`.
  - `out_data` = head entry; value is don't-care when `out_valid` is low.
- **Pointers:** read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full: MSBs differ and the remaining bits are equal.
  - empty: pointers equal.
  - level = write pointer − read pointer, modulo 2·DEPTH.
- **Sticky flags:** `clr_flags` clears both. If a new error event occurs in the same cycle as `clr_flags`, the event wins and the flag stays set.
- **Independence:** all four FIFO operations (two pushes, two pops) may occur in the same cycle, each evaluated against pre-edge state, except for the output-FIFO full-bypass rule above.

## Timing
- **Reset values:** pointers 0; `in_ready`=1; `out_valid`=0; `arch_input_value`=0; flags 0; levels 0; stats 0.
- Reset mid-transfer discards all FIFO contents immediately; storage RAM is not cleared.
- **Input path latency:** a host byte accepted at edge N appears on `arch_input_value` after edge N. The CPU can capture it at edge N+1.
- **Output path latency:** a CPU write at edge N raises `out_valid` after edge N.
- `in_ready`, `out_valid`, levels and flags are registered-state functions. They are never combinational from same-cycle inputs.

## Configuration
- **`OVERTURE_IO_STATS_EN`**
  - Defined: adds outputs `rd_count` and `wr_count`, 16 bits each.
  - They count successful CPU pops and successful CPU pushes respectively.
  - Both saturate at 0xFFFF, reset to 0, and clear on `clr_flags`. An increment in the same cycle as `clr_flags` yields 1.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- **Shared package `overture_io_pkg`:** default `BIT_WIDTH`, the stats counter width, and the `ptr_t`/`level_t` width helper.
- **Sub-module `overture_io_fifo`:**
  - Parameterised synchronous FIFO, instantiated twice.
  - Exposes push, pop, head, full, empty, level, and a `pop_same_cycle_bypass` enable.
  - The enable is 0 on the input instance and 1 on the output instance.
- The top level holds only handshake glue, flags and stats.

## Test plan
- **Basic read:** host pushes 0x11, 0x22, 0x33, then CPU strobes `arch_input_enable` 3 cycles → values read are 0x11, 0x22, 0x33; `in_level` goes 3→0; `in_underflow`=0.
- **Underflow:** CPU strobes on an empty FIFO → `arch_input_value`=0, `in_underflow`=1. Then `clr_flags` → 0. Then `clr_flags` plus an empty read in the same cycle → remains 1.
- **Input full:** push DEPTH=16 bytes → `in_ready`=0 and the 17th `in_valid` is not accepted. A push and CPU pop in the same cycle at full → level 15, the host byte is not taken.
- **Output overflow:**
  - 17 CPU writes 0x00..0x10 with `out_ready`=0 → `out_overflow`=1, and the host drains 0x00..0x0F.
  - Repeat fill to full, then write with `out_ready`=1 → write accepted, level stays 16.
- **Concurrent traffic:** random host traffic on both sides plus CPU strobes for 10k cycles → a scoreboard shows order preserved and levels always consistent. Assert `rst` mid-stream → all levels 0, `in_ready`=1, `out_valid`=0.
- **With `OVERTURE_IO_STATS_EN`:** 5 reads and 3 writes → `rd_count`=5, `wr_count`=3. Forcing 0xFFFF plus one more event → stays at 0xFFFF.

Source files
------------

// File: rtl/overture_io_pkg.sv
// Shared definitions for the OVERTURE host I/O endpoint: default data width,
// statistics counter width and the pointer/level width helper.
package overture_io_pkg;

   localparam int BIT_WIDTH_DEF = 8;
   localparam int STATS_W       = 16;

   // Pointer and level width: one extra bit over the address so that
   // full and empty can be told apart when the addresses match.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 32'd1;
   endfunction

endpackage

// File: rtl/overture_io_fifo.sv
// Synchronous FIFO used for both directions of the OVERTURE host endpoint.
// Pointers carry one wrap bit (modulo 2*DEPTH). When pop_same_cycle_bypass
// is set, a push into a full FIFO is accepted if a pop happens on the
// same edge. The new byte then lands in the slot being vacated.
module overture_io_fifo
   import overture_io_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [BIT_WIDTH-1:0]   push_data,
   input  logic                   pop,
   input  logic                   pop_same_cycle_bypass,
   output logic [BIT_WIDTH-1:0]   head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   push_done,
   output logic                   pop_done
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

   logic [BIT_WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]        wr_ptr_r;
   logic [PW-1:0]        rd_ptr_r;
   logic                 full_s;
   logic                 empty_s;
   logic                 push_fire_s;
   logic                 pop_fire_s;

   // Status decode from the pointers and the gating of push and pop.
   always_comb begin
      empty_s    = (wr_ptr_r == rd_ptr_r);
      full_s     = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_fire_s = pop && !empty_s;
      if (full_s) begin
         push_fire_s = push && pop_same_cycle_bypass && pop_fire_s;
      end else begin
         push_fire_s = push;
      end
   end

   // Pointer advance; reset discards contents by collapsing the pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else begin
         if (push_fire_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_fire_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Storage write; the array is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (push_fire_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   assign head      = mem_r[rd_ptr_r[AW-1:0]];
   assign full      = full_s;
   assign empty     = empty_s;
   assign level     = wr_ptr_r - rd_ptr_r;
   assign push_done = push_fire_s;
   assign pop_done  = pop_fire_s;

endmodule

// File: rtl/overture_io_host.sv
// Host-side I/O endpoint for the OVERTURE 8-bit CPU. The input FIFO is filled
// by the host and drained by CPU reads. The output FIFO is filled by CPU
// writes and drained by the host. The CPU cannot stall, so sticky flags
// report reads from an empty FIFO and writes into a full one.
// Build option: define OVERTURE_IO_STATS_EN to add the rd_count and
// wr_count saturating statistics outputs.
module overture_io_host
   import overture_io_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   arch_input_enable,
   output logic [BIT_WIDTH-1:0]   arch_input_value,
   input  logic                   arch_output_enable,
   input  logic [BIT_WIDTH-1:0]   arch_output_value,
   input  logic                   in_valid,
   input  logic [BIT_WIDTH-1:0]   in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [BIT_WIDTH-1:0]   out_data,
   input  logic                   out_ready,
   input  logic                   clr_flags,
   output logic                   in_underflow,
   output logic                   out_overflow,
   output logic [$clog2(DEPTH):0] in_level,
   output logic [$clog2(DEPTH):0] out_level
`ifdef OVERTURE_IO_STATS_EN
   ,
   output logic [STATS_W-1:0]     rd_count,
   output logic [STATS_W-1:0]     wr_count
`endif
);

   logic [BIT_WIDTH-1:0] in_head_s;
   logic                 in_full_s;
   logic                 in_empty_s;
   logic                 in_push_done_s;
   logic                 in_pop_done_s;
   logic                 out_full_s;
   logic                 out_empty_s;
   logic                 out_push_done_s;
   logic                 out_pop_done_s;
   logic                 underflow_ev_s;
   logic                 overflow_ev_s;
   logic                 in_underflow_r;
   logic                 out_overflow_r;

   overture_io_fifo #(
      .DEPTH     (DEPTH),
      .BIT_WIDTH (BIT_WIDTH)
   ) u_in_fifo (
      .clk                   (clk),
      .rst                   (rst),
      .push                  (in_valid),
      .push_data             (in_data),
      .pop                   (arch_input_enable),
      .pop_same_cycle_bypass (1'b0),
      .head                  (in_head_s),
      .full                  (in_full_s),
      .empty                 (in_empty_s),
      .level                 (in_level),
      .push_done             (in_push_done_s),
      .pop_done              (in_pop_done_s)
   );

   overture_io_fifo #(
      .DEPTH     (DEPTH),
      .BIT_WIDTH (BIT_WIDTH)
   ) u_out_fifo (
      .clk                   (clk),
      .rst                   (rst),
      .push                  (arch_output_enable),
      .push_data             (arch_output_value),
      .pop                   (out_ready),
      .pop_same_cycle_bypass (1'b1),
      .head                  (out_data),
      .full                  (out_full_s),
      .empty                 (out_empty_s),
      .level                 (out_level),
      .push_done             (out_push_done_s),
      .pop_done              (out_pop_done_s)
   );

   // Error events: a CPU read with nothing to read, or a CPU write the FIFO refused.
   always_comb begin
      underflow_ev_s = arch_input_enable && in_empty_s;
      overflow_ev_s  = arch_output_enable && !out_push_done_s;
   end

   // Sticky error flags; a new event in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_underflow_r <= 1'b0;
         out_overflow_r <= 1'b0;
      end else begin
         if (underflow_ev_s) begin
            in_underflow_r <= 1'b1;
         end else if (clr_flags) begin
            in_underflow_r <= 1'b0;
         end
         if (overflow_ev_s) begin
            out_overflow_r <= 1'b1;
         end else if (clr_flags) begin
            out_overflow_r <= 1'b0;
         end
      end
   end

   assign in_ready         = !in_full_s;
   assign out_valid        = !out_empty_s;
   assign arch_input_value = in_empty_s ? {BIT_WIDTH{1'b0}} : in_head_s;
   assign in_underflow     = in_underflow_r;
   assign out_overflow     = out_overflow_r;

`ifdef OVERTURE_IO_STATS_EN
   localparam logic [STATS_W-1:0] CNT_ONE = {{(STATS_W-1){1'b0}}, 1'b1};
   localparam logic [STATS_W-1:0] CNT_MAX = {STATS_W{1'b1}};

   logic [STATS_W-1:0] rd_count_r;
   logic [STATS_W-1:0] wr_count_r;
   logic               unused_s;

   // Saturating counts of successful CPU pops and pushes, cleared with the flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count_r <= {STATS_W{1'b0}};
         wr_count_r <= {STATS_W{1'b0}};
      end else if (clr_flags) begin
         rd_count_r <= in_pop_done_s   ? CNT_ONE : {STATS_W{1'b0}};
         wr_count_r <= out_push_done_s ? CNT_ONE : {STATS_W{1'b0}};
      end else begin
         if (in_pop_done_s && (rd_count_r != CNT_MAX)) begin
            rd_count_r <= rd_count_r + CNT_ONE;
         end
         if (out_push_done_s && (wr_count_r != CNT_MAX)) begin
            wr_count_r <= wr_count_r + CNT_ONE;
         end
      end
   end

   assign rd_count = rd_count_r;
   assign wr_count = wr_count_r;
   assign unused_s = &{1'b0, in_push_done_s, out_pop_done_s, out_full_s};
`else
   // Without statistics the pop strobe of the input FIFO has no consumer.
   logic unused_s;
   assign unused_s = &{1'b0, in_push_done_s, in_pop_done_s, out_pop_done_s, out_full_s};
`endif

endmodule
